// File: rtl/player_motion_ctrl_if.sv
// Bus between the keypad/collision logic, the player motion controller and the sprite drawer.
// player_state packs {img_id, x, y, width, height} as five 11-bit fields, img_id first.
interface player_motion_ctrl_if #(
  parameter int MAX_SPEED = 15
);
  localparam int SPEED_W = $clog2(MAX_SPEED + 1);

  logic               frame_start;
  logic               left_pressed;
  logic               right_pressed;
  logic               gas_pressed;
  logic               hit;
  logic [0:4][0:10]   player_state;
  logic [SPEED_W-1:0] speed;
  logic               crashed;
  logic               visible;
  logic               crash_pulse;

  modport master (
    output frame_start, left_pressed, right_pressed, gas_pressed, hit,
    input  player_state, speed, crashed, visible, crash_pulse
  );

  modport slave (
    input  frame_start, left_pressed, right_pressed, gas_pressed, hit,
    output player_state, speed, crashed, visible, crash_pulse
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Player car motion and crash controller, stepping once per video frame (DRIVE/CRASH[/RESPAWN]).
// Define PLAYER_RESPAWN_BLINK_EN to add the blinking, hit-immune respawn window after a crash.
module player_motion_ctrl #(
  parameter int MIN_X                = 166,
  parameter int MAX_X                = 414,
  parameter int START_X              = 272,
  parameter int START_Y              = 380,
  parameter int SPRITE_W             = 64,
  parameter int SPRITE_H             = 64,
  parameter int STEP_X               = 2,
  parameter int MAX_SPEED            = 15,
  parameter int ACCEL_DIV            = 4,
  parameter int CRASH_IMG_BASE       = 99,
  parameter int CRASH_IMG_COUNT      = 13,
  parameter int CRASH_FRAMES_PER_IMG = 8,
  parameter int RESPAWN_FRAMES       = 64
) (
  input  logic                clk,
  input  logic                resetN,
  player_motion_ctrl_if.slave bus
);
  localparam int SPEED_W     = $clog2(MAX_SPEED + 1);
  localparam int ACC_W       = $clog2(ACCEL_DIV + 1);
  localparam int CRASH_TOTAL = CRASH_IMG_COUNT * CRASH_FRAMES_PER_IMG;
  localparam int PHASE_TOP   = (CRASH_TOTAL > RESPAWN_FRAMES) ? CRASH_TOTAL : RESPAWN_FRAMES;
  localparam int PHASE_W     = $clog2(PHASE_TOP + 1);

  localparam logic [10:0] MIN_X_C   = 11'(MIN_X);
  localparam logic [10:0] MAX_X_C   = 11'(MAX_X);
  localparam logic [10:0] X_HI_C    = 11'(MAX_X - SPRITE_W);
  localparam logic [10:0] START_X_C = 11'(START_X);
  localparam logic [10:0] STEP_C    = 11'(STEP_X);
  localparam logic [10:0] W_C       = 11'(SPRITE_W);
  localparam logic [10:0] BASE_C    = 11'(CRASH_IMG_BASE);

`ifdef PLAYER_RESPAWN_BLINK_EN
  typedef enum logic [1:0] {DRIVE, CRASH, RESPAWN} state_t;
`else
  typedef enum logic [1:0] {DRIVE, CRASH} state_t;
`endif

  state_t             state;
  logic [10:0]        x;
  logic [10:0]        img;
  logic [SPEED_W-1:0] speed;
  logic [ACC_W-1:0]   acc_cnt;
  logic [PHASE_W-1:0] phase;
  logic               dir;
  logic               gas_prev;
  logic               crashed_q;
  logic               crash_pulse_q;
`ifdef PLAYER_RESPAWN_BLINK_EN
  logic               visible_q;
`endif

  logic               accel_step;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   acc_inc;
  logic [ACC_W-1:0]   acc_next;
  logic [SPEED_W-1:0] speed_next;
  logic               steer_r;
  logic               steer_l;
  logic [10:0]        x_steer;
  logic [10:0]        x_drift;
  logic               wall_crash;
  logic               crash_now;
  logic               dir_next;
  logic [PHASE_W-1:0] phase_inc;

  // Driving-mode next values; dir=1 means right. Bound checks stay additive so nothing underflows.
  always_comb begin
    acc_base   = (bus.gas_pressed != gas_prev) ? '0 : acc_cnt;
    acc_inc    = acc_base + ACC_W'(1);
    accel_step = (acc_inc == ACC_W'(ACCEL_DIV));
    acc_next   = accel_step ? '0 : acc_inc;
    speed_next = speed;
    if (accel_step) begin
      if (bus.gas_pressed && speed != SPEED_W'(MAX_SPEED)) speed_next = speed + SPEED_W'(1);
      else if (!bus.gas_pressed && speed != '0)            speed_next = speed - SPEED_W'(1);
    end
    steer_r    = (speed != '0) && bus.right_pressed;
    steer_l    = (speed != '0) && bus.left_pressed && !bus.right_pressed;
    x_steer    = x;
    wall_crash = 1'b0;
    if (steer_r) begin
      if (x + STEP_C + W_C <= MAX_X_C) x_steer = x + STEP_C;
      else                              wall_crash = 1'b1;
    end else if (steer_l) begin
      if (x >= MIN_X_C + STEP_C) x_steer = x - STEP_C;
      else                        wall_crash = 1'b1;
    end
    dir_next  = steer_r ? 1'b1 : (steer_l ? 1'b0 : dir);
    crash_now = wall_crash || (bus.hit && state == DRIVE);
    if (dir) x_drift = (x + 11'd1 + W_C <= MAX_X_C) ? x + 11'd1 : X_HI_C;
    else     x_drift = (x >= MIN_X_C + 11'd1) ? x - 11'd1 : MIN_X_C;
    phase_inc = phase + PHASE_W'(1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= DRIVE;
      x             <= START_X_C;
      img           <= '0;
      speed         <= '0;
      acc_cnt       <= '0;
      phase         <= '0;
      dir           <= 1'b0;
      gas_prev      <= 1'b0;
      crashed_q     <= 1'b0;
      crash_pulse_q <= 1'b0;
`ifdef PLAYER_RESPAWN_BLINK_EN
      visible_q     <= 1'b1;
`endif
    end else begin
      crash_pulse_q <= 1'b0;
      if (bus.frame_start) begin
        gas_prev <= bus.gas_pressed;
        if (state == CRASH) begin
          if (phase == PHASE_W'(CRASH_TOTAL - 1)) begin
            x         <= START_X_C;
            img       <= '0;
            phase     <= '0;
            crashed_q <= 1'b0;
`ifdef PLAYER_RESPAWN_BLINK_EN
            state     <= RESPAWN;
            visible_q <= 1'b1;
`else
            state     <= DRIVE;
`endif
          end else begin
            phase <= phase_inc;
            x     <= x_drift;
            img   <= BASE_C + 11'(phase_inc / CRASH_FRAMES_PER_IMG);
          end
        end else begin
          dir <= dir_next;
          if (crash_now) begin
            state         <= CRASH;
            crashed_q     <= 1'b1;
            crash_pulse_q <= 1'b1;
            speed         <= '0;
            acc_cnt       <= '0;
            phase         <= '0;
            img           <= BASE_C;
`ifdef PLAYER_RESPAWN_BLINK_EN
            visible_q     <= 1'b1;
`endif
          end else begin
            x       <= x_steer;
            speed   <= speed_next;
            acc_cnt <= acc_next;
`ifdef PLAYER_RESPAWN_BLINK_EN
            // Blink with a period of 8 frames until the window has elapsed.
            if (state == RESPAWN) begin
              if (phase == PHASE_W'(RESPAWN_FRAMES - 1)) begin
                state     <= DRIVE;
                phase     <= '0;
                visible_q <= 1'b1;
              end else begin
                phase     <= phase_inc;
                visible_q <= ~phase_inc[2];
              end
            end
`endif
          end
        end
      end
    end
  end

  assign bus.player_state = {img, x, 11'(START_Y), 11'(SPRITE_W), 11'(SPRITE_H)};
  assign bus.speed        = speed;
  assign bus.crashed      = crashed_q;
  assign bus.crash_pulse  = crash_pulse_q;
`ifdef PLAYER_RESPAWN_BLINK_EN
  assign bus.visible      = visible_q;
`else
  assign bus.visible      = 1'b1;
`endif
endmodule
